// File: rtl/ps2kbd_wb8.sv
// PS/2 keyboard receiver with a 16-byte receive FIFO behind an 8-bit
// Wishbone-style register port. Frames are sampled on falling edges of the
// synchronised PS/2 clock; accepted bytes raise a level interrupt.
module ps2kbd_wb8 #(
    parameter int CLOCKFREQ  = 25125000,
    parameter int TIMEOUT_US = 100
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic [7:0] O_wb_dat,
    output logic       O_wb_ack,
    input  logic       I_ps2_clk,
    input  logic       I_ps2_dat,
    output logic       O_interrupt
);

    // Inter-edge timeout in system clock cycles (integer MHz times microseconds).
    localparam int unsigned LIMIT   = (CLOCKFREQ / 1000000) * TIMEOUT_US;
    localparam int unsigned LIMIT_C = (LIMIT < 2) ? 2 : LIMIT;
    localparam int unsigned TO_W    = $clog2(LIMIT_C + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Line synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic ps2_fall;

    // Two-stage synchronisers; idle PS/2 lines are high.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= I_ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= I_ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign ps2_fall = clk_prev & ~clk_s2;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t       state, state_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            bit_clr, shift_en, par_en;
    logic            frame_ok, frame_bad;
    logic            push_req;

    assign timeout = (to_cnt == TO_W'(LIMIT_C - 1));

    // Receiver state register.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and datapath controls; an edge takes priority over timeout.
    always_comb begin
        state_next = state;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (ps2_fall && !dat_s2) begin
                    state_next = DATA;
                    bit_clr    = 1'b1;
                end
            end
            DATA: begin
                if (ps2_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end else if (timeout) begin
                    state_next = IDLE;
                    frame_bad  = 1'b1;
                end
            end
            PARITY: begin
                if (ps2_fall) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end else if (timeout) begin
                    state_next = IDLE;
                    frame_bad  = 1'b1;
                end
            end
            STOP: begin
                if (ps2_fall) begin
                    state_next = IDLE;
                    if (dat_s2 && (^{shift_q, par_q})) frame_ok  = 1'b1;
                    else                               frame_bad = 1'b1;
                end else if (timeout) begin
                    state_next = IDLE;
                    frame_bad  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit counter, LSB-first shift register, parity latch and push request.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            push_req <= 1'b0;
        end else begin
            push_req <= frame_ok;
            if (bit_clr) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {dat_s2, shift_q[7:1]};
            end
            if (par_en) par_q <= dat_s2;
        end
    end

    // Cycles since the last edge; held at zero whenever the receiver idles.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset)                             to_cnt <= '0;
        else if (state_next == IDLE || ps2_fall) to_cnt <= '0;
        else                                     to_cnt <= to_cnt + TO_W'(1);
    end

    // ------------------------------------------------------------------
    // Bus side and FIFO
    // ------------------------------------------------------------------
    logic [7:0] mem [16];
    logic [3:0] wr_ptr, rd_ptr;
    logic [4:0] count, count_next;
    logic       ferr, ovf;
    logic       wb_start, do_pop, do_write, ovf_set;
    logic       clr_ferr, clr_ovf;
    logic [7:0] rd_mux;
    logic       unused_wdat;

    assign unused_wdat = ^{I_wb_dat[7:4], I_wb_dat[1:0]};

    assign wb_start = I_wb_stb & ~O_wb_ack;

    // Transfer decode, FIFO occupancy update and read-data selection.
    always_comb begin
        do_pop     = wb_start && !I_wb_we && (I_wb_adr == 2'd0) && (count != 5'd0);
        do_write   = push_req && ((count != 5'd16) || do_pop);
        ovf_set    = push_req && !do_write;
        count_next = count + 5'(do_write) - 5'(do_pop);
        clr_ferr   = wb_start && I_wb_we && (I_wb_adr == 2'd1) && I_wb_dat[3];
        clr_ovf    = wb_start && I_wb_we && (I_wb_adr == 2'd1) && I_wb_dat[2];
        rd_mux     = 8'h00;
        case (I_wb_adr)
            2'd0:    rd_mux = (count != 5'd0) ? mem[rd_ptr] : 8'h00;
            2'd1:    rd_mux = {4'b0, ferr, ovf, count == 5'd16, count != 5'd0};
            2'd2:    rd_mux = {3'b0, count};
            default: rd_mux = 8'h00;
        endcase
    end

    // FIFO storage; at full a coincident pop frees the slot being written.
    always_ff @(posedge I_wb_clk) begin
        if (do_write) mem[wr_ptr] <= shift_q;
    end

    // Pointers, count, interrupt and sticky error flags (set beats clear).
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            O_interrupt <= 1'b0;
            ferr        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 4'd1;
            if (do_pop)   rd_ptr <= rd_ptr + 4'd1;
            count       <= count_next;
            O_interrupt <= (count_next != 5'd0);
            if (frame_bad)     ferr <= 1'b1;
            else if (clr_ferr) ferr <= 1'b0;
            if (ovf_set)       ovf  <= 1'b1;
            else if (clr_ovf)  ovf  <= 1'b0;
        end
    end

    // Registered acknowledge and read data; data holds between transfers.
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            O_wb_ack <= 1'b0;
            O_wb_dat <= 8'h00;
        end else begin
            O_wb_ack <= wb_start;
            if (wb_start) O_wb_dat <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ps2kbd_wb8.sv
// Testbench for ps2kbd_wb8: PS/2 frames are bit-banged at 10 kHz, bus
// accesses record their expected response in a scoreboard queue, and a
// monitor compares each acknowledged read against it.
module tb_ps2kbd_wb8;

    // 1 MHz system clock keeps a 10 kHz PS/2 bit at 100 cycles; the 150 us
    // timeout (150 cycles) then sits between a bit gap and a 200 us idle.
    localparam int CF = 1_000_000;
    localparam int TO = 150;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] wb_adr = '0;
    logic [7:0] wb_wdat = '0;
    logic       wb_stb = 1'b0;
    logic       wb_we = 1'b0;
    logic [7:0] wb_rdat;
    logic       wb_ack;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       chk;
        logic [1:0] adr;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovf  = 1'b0;

    ps2kbd_wb8 #(.CLOCKFREQ(CF), .TIMEOUT_US(TO)) dut (
        .I_wb_clk   (clk),
        .I_reset    (rst),
        .I_wb_adr   (wb_adr),
        .I_wb_dat   (wb_wdat),
        .I_wb_stb   (wb_stb),
        .I_wb_we    (wb_we),
        .O_wb_dat   (wb_rdat),
        .O_wb_ack   (wb_ack),
        .I_ps2_clk  (ps2_clk),
        .I_ps2_dat  (ps2_dat),
        .O_interrupt(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, expv);
        end
    endtask

    // Reference model of the register file; computes the response of one access.
    task automatic expect_access(input logic we, input logic [1:0] adr, input logic [7:0] d);
        exp_t e;
        e.chk = ~we;
        e.adr = adr;
        e.val = 8'h00;
        if (!we) begin
            case (adr)
                2'd0: if (model_q.size() > 0) e.val = model_q.pop_front();
                2'd1: e.val = {4'b0, m_ferr, m_ovf, model_q.size() == 16, model_q.size() != 0};
                2'd2: e.val = 8'(model_q.size());
                default: e.val = 8'h00;
            endcase
        end else if (adr == 2'd1) begin
            if (d[3]) m_ferr = 1'b0;
            if (d[2]) m_ovf  = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Frame acceptance rule: stop bit high and odd parity over data plus parity.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (stop && (($countones(d) + int'(par)) % 2 == 1)) begin
            if (model_q.size() < 16) model_q.push_back(d);
            else                     m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] d);
        int n;
        @(negedge clk);
        expect_access(we, adr, d);
        wb_we = we; wb_adr = adr; wb_wdat = d; wb_stb = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wb_ack && n < 4) begin
            @(negedge clk);
            n++;
        end
        wb_stb = 1'b0;
        check("ack_arrives", {7'b0, wb_ack}, 8'h01);
    endtask

    // One PS/2 bit; with hook set, a FIFO read is timed to be acknowledged in
    // the very cycle the receiver pushes the byte completed by this edge.
    task automatic ps2_bit(input logic b, input logic hook);
        ps2_dat = b;
        repeat (25) @(negedge clk);
        ps2_clk = 1'b0;
        if (hook) begin
            repeat (3) @(negedge clk);
            expect_access(1'b0, 2'd0, 8'h00);
            wb_we = 1'b0; wb_adr = 2'd0; wb_stb = 1'b1;
            @(negedge clk);
            wb_stb = 1'b0;
            repeat (46) @(negedge clk);
        end else begin
            repeat (50) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic hook);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, hook);
        model_frame(d, par, stop);
    endtask

    task automatic check_irq(input string name);
        @(negedge clk);
        check(name, {7'b0, irq}, {7'b0, model_q.size() != 0});
    endtask

    // Scoreboard monitor: every acknowledge consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data 0x%02h, expected no ack", wb_rdat);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (wb_rdat !== e.val) begin
                        errors++;
                        $display("FAIL read_adr%0d: got 0x%02h, expected 0x%02h", e.adr, wb_rdat, e.val);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p, s;
        int         nops;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ack", {7'b0, wb_ack}, 8'h00);
        check("reset_dat", wb_rdat, 8'h00);
        check("reset_irq", {7'b0, irq}, 8'h00);
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b0, 2'd1, 8'h00);
        bus(1'b0, 2'd3, 8'h00);
        bus(1'b0, 2'd0, 8'h00);

        // Valid 0x1C frame, read back.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_irq("irq_after_1c");
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b0, 2'd0, 8'h00);
        bus(1'b0, 2'd2, 8'h00);
        check_irq("irq_after_pop");

        // Bad parity sets FERR; write-one clears it.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        bus(1'b0, 2'd1, 8'h00);
        bus(1'b1, 2'd1, 8'h08);
        bus(1'b0, 2'd1, 8'h00);

        // Truncated frame then 200 us idle, followed by a clean 0xF0.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        repeat (200) @(negedge clk);
        m_ferr = 1'b1;
        bus(1'b0, 2'd1, 8'h00);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        bus(1'b0, 2'd1, 8'h00);
        bus(1'b0, 2'd0, 8'h00);
        bus(1'b1, 2'd1, 8'h0C);

        // Reset during bit 5 of a frame, then a clean 0x5A.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0);
        ps2_dat = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rst = 1'b0;
        model_q.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        repeat (30) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        bus(1'b0, 2'd1, 8'h00);
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b0, 2'd0, 8'h00);

        // 17 frames with no reads: full plus one overflow, then drain in order.
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            send_frame(d, ~^d, 1'b1, 1'b0);
        end
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b0, 2'd1, 8'h00);
        check_irq("irq_full");
        for (int i = 0; i < 16; i++) bus(1'b0, 2'd0, 8'h00);
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b1, 2'd1, 8'h04);

        // Full FIFO with a read acknowledged in the push cycle: no overflow.
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_frame(d, ~^d, 1'b1, 1'b0);
        end
        send_frame(8'hA7, ~^8'hA7, 1'b1, 1'b1);
        bus(1'b0, 2'd2, 8'h00);
        bus(1'b0, 2'd1, 8'h00);
        for (int i = 0; i < 16; i++) bus(1'b0, 2'd0, 8'h00);
        check_irq("irq_drained");

        // Randomised frames interleaved with random register traffic.
        for (int i = 0; i < 15; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 5) == 0) ? ^d : ~^d;
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 1'b0);
            nops = $urandom_range(0, 3);
            for (int k = 0; k < nops; k++)
                bus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 8'($urandom));
            check_irq("irq_random");
        end
        bus(1'b0, 2'd1, 8'h00);
        bus(1'b0, 2'd2, 8'h00);

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2kbd_wb8.md
PS2KBD_WB8 -- requirements
Module: ps2kbd_wb8

Interface
REQ-001 SHALL have parameter CLOCKFREQ, default 25125000, meaning the I_wb_clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 100, meaning the maximum permitted gap between PS/2 falling edges inside one frame.
REQ-003 SHALL have port I_wb_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port I_reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port I_wb_adr  in  2  register select.
REQ-006 SHALL have port I_wb_dat  in  8  write data.
REQ-007 SHALL have port I_wb_stb  in  1  bus strobe from the address decoder (0xFFFFFAxx).
REQ-008 SHALL have port I_wb_we  in  1  write enable.
REQ-009 SHALL have port O_wb_dat  out  8  read data.
REQ-010 SHALL have port O_wb_ack  out  1  transfer acknowledge.
REQ-011 SHALL have port I_ps2_clk  in  1  asynchronous PS/2 clock line.
REQ-012 SHALL have port I_ps2_dat  in  1  asynchronous PS/2 data line.
REQ-013 SHALL have port O_interrupt  out  1  level interrupt, high while the FIFO is non-empty.

Function
REQ-014 SHALL synchronise I_ps2_clk and I_ps2_dat through two flip-flops each, and sample data on the synchronised clock falling edge (1->0 between consecutive synchronised samples).
REQ-015 SHALL implement receiver states IDLE, DATA, PARITY, STOP.
- IDLE: on an edge with data=0, enter DATA with bit count 0; an edge with data=1 is ignored.
- DATA: shift the sampled bit into the byte LSB-first; after 8 bits, enter PARITY.
- PARITY: latch the bit, then enter STOP.
- STOP: return to IDLE.
REQ-016 SHALL accept a frame when the stop bit is 1 and data bits plus parity bit have odd parity.
- Accepted: push the byte to the FIFO on the cycle after the stop-bit edge.
- Otherwise: discard the byte and set the sticky FERR flag.
REQ-017 SHALL count cycles since the last edge while not in IDLE.
- Limit: CLOCKFREQ/1000000*TIMEOUT_US cycles.
- On reaching the limit: return to IDLE, discard the partial byte, set FERR.
REQ-018 SHALL provide a 16-entry x 8-bit FIFO with a 5-bit count (0..16); read/write pointers wrap 15->0.
REQ-019 SHALL, on push while count=16 and no pop in the same cycle, drop the byte, leave FIFO contents unchanged, and set the sticky OVF flag.
REQ-020 SHALL, on simultaneous push and pop, perform both; count stays unchanged, including at count=16 (no OVF) and count=0 (pop ignored, push accepted, count becomes 1).
REQ-021 SHALL register map:
- adr 0 read: FIFO head byte, popped; reads 0x00 with no pop when empty.
- adr 1 read: status {4'b0, FERR, OVF, full, nonempty}.
- adr 1 write: clears FERR/OVF where the corresponding data bit is 1.
- adr 2 read: {3'b0, count}.
- adr 3: reads 0x00.
- Writes to adr 0, 2 and 3 are ignored.
REQ-022 SHALL drive O_wb_ack and O_wb_dat registered.
- ack=1 in the cycle after I_wb_stb=1 is sampled with ack=0; ack=0 in the following cycle.
- A strobe held high therefore yields alternating acks.
REQ-023 SHALL perform exactly one pop and one register side effect per acknowledged transfer, in the cycle ack is driven.
REQ-024 SHALL keep O_wb_dat valid in the ack cycle, and hold it at its last value otherwise.
REQ-025 SHALL drive O_interrupt = (count != 0), registered with the count.

Reset
REQ-026 SHALL, while I_reset=1 on a clock edge, set:
- receiver to IDLE; bit count, timeout counter, shift register to 0;
- FIFO pointers and count to 0; FERR=OVF=0;
- O_wb_ack=0, O_wb_dat=0x00, O_interrupt=0;
- synchronisers to 1 (idle lines).
REQ-027 SHALL abandon any frame in progress when reset is asserted mid-frame, with no push and no FERR.

Verification
REQ-028 SHALL pass: valid frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at 10 kHz PS/2 clock -> count=1, interrupt=1, adr0 read returns 0x1C, then count=0, interrupt=0.
REQ-029 SHALL pass: 0x1C frame with parity bit 1 -> no push, status=0x08; write 0x08 to adr1 -> status=0x00.
REQ-030 SHALL pass: 17 valid frames, no reads -> count=16, status=0x07; then 16 adr0 reads return the first 16 bytes in order.
REQ-031 SHALL pass: start bit plus 3 data bits, then lines idle 200 us -> FERR=1, receiver IDLE; next full frame 0xF0 is received correctly.
REQ-032 SHALL pass: I_reset pulsed during bit 5 of a frame, then a clean 0x5A frame -> count=1, FERR=0, adr0 read returns 0x5A.
REQ-033 SHALL pass: with FIFO full, adr0 read ack coincides with a frame push -> count stays 16, OVF=0, newest byte is at the tail.
